// File: rtl/rename_regfile_if.sv
// rtl/rename_regfile_if.sv - dispatch-side bundle between decoder/ROB and the rename register file
interface rename_regfile_if #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              rdy;
  logic              dec_valid;
  logic [REG_W-1:0]  dec_rs1;
  logic [REG_W-1:0]  dec_rs2;
  logic [REG_W-1:0]  dec_rd;
  logic [TAG_W-1:0]  dec_tag;
  logic              cmt_valid;
  logic [REG_W-1:0]  cmt_rd;
  logic [TAG_W-1:0]  cmt_tag;
  logic [DATA_W-1:0] cmt_data;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_v1;
  logic [DATA_W-1:0] out_v2;
  logic [TAG_W-1:0]  out_q1;
  logic [TAG_W-1:0]  out_q2;
  logic              out_busy1;
  logic              out_busy2;
  logic [REG_W-1:0]  out_rd;
  logic [TAG_W-1:0]  out_tag;

  // Decoder/ROB side drives requests and consumes the operand bundle.
  modport master (
    output rdy, dec_valid, dec_rs1, dec_rs2, dec_rd, dec_tag,
    output cmt_valid, cmt_rd, cmt_tag, cmt_data, flush,
    input  out_valid, out_v1, out_v2, out_q1, out_q2, out_busy1, out_busy2, out_rd, out_tag
  );

  // Register file side.
  modport slave (
    input  rdy, dec_valid, dec_rs1, dec_rs2, dec_rd, dec_tag,
    input  cmt_valid, cmt_rd, cmt_tag, cmt_data, flush,
    output out_valid, out_v1, out_v2, out_q1, out_q2, out_busy1, out_busy2, out_rd, out_tag
  );
endinterface

// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - architectural register file with rename tags; optional COMMIT_BYPASS_EN
module rename_regfile #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int REG_W   = $clog2(REG_NUM)
) (
  input logic              clk,
  input logic              rst,
  rename_regfile_if.slave  bus
);

  logic [DATA_W-1:0] value_q [REG_NUM];
  logic [DATA_W-1:0] value_d [REG_NUM];
  logic [TAG_W-1:0]  tag_q   [REG_NUM];
  logic [TAG_W-1:0]  tag_d   [REG_NUM];
  logic [REG_NUM-1:0] busy_q, busy_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_v_q   [2];
  logic [DATA_W-1:0] out_v_d   [2];
  logic [TAG_W-1:0]  out_q_q   [2];
  logic [TAG_W-1:0]  out_q_d   [2];
  logic [1:0]        out_busy_q, out_busy_d;
  logic [REG_W-1:0]  out_rd_q, out_rd_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;

  logic [REG_W-1:0]  src [2];
  logic [DATA_W-1:0] op_val [2];
  logic [TAG_W-1:0]  op_tag [2];
  logic [1:0]        op_busy;
  logic              cmt_hit;

  assign src[0] = bus.dec_rs1;
  assign src[1] = bus.dec_rs2;

  // A commit only retires the producer if the register still waits on that exact tag.
  assign cmt_hit = bus.cmt_valid && (bus.cmt_rd != '0) && busy_q[bus.cmt_rd]
                   && (tag_q[bus.cmt_rd] == bus.cmt_tag);

  // Source operand lookup against the mapping as it stood before this cycle's rename.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      op_val[k]  = value_q[src[k]];
      op_tag[k]  = tag_q[src[k]];
      op_busy[k] = busy_q[src[k]];
      if (src[k] == '0) begin
        op_val[k]  = '0;
        op_busy[k] = 1'b0;
      end
`ifdef COMMIT_BYPASS_EN
      else if (bus.cmt_valid && (bus.cmt_rd == src[k]) && busy_q[src[k]]
               && (tag_q[src[k]] == bus.cmt_tag)) begin
        op_val[k]  = bus.cmt_data;
        op_busy[k] = 1'b0;
      end
`endif
    end
  end

  // Next state: commit writes value even under flush; rename wins over a same-cycle clear.
  always_comb begin
    value_d     = value_q;
    tag_d       = tag_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_v_d     = out_v_q;
    out_q_d     = out_q_q;
    out_busy_d  = out_busy_q;
    out_rd_d    = out_rd_q;
    out_tag_d   = out_tag_q;
    if (bus.cmt_valid && (bus.cmt_rd != '0)) begin
      value_d[bus.cmt_rd] = bus.cmt_data;
    end
    if (bus.flush) begin
      busy_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      if (cmt_hit) begin
        busy_d[bus.cmt_rd] = 1'b0;
      end
      if (bus.dec_valid && (bus.dec_rd != '0)) begin
        busy_d[bus.dec_rd] = 1'b1;
        tag_d[bus.dec_rd]  = bus.dec_tag;
      end
      out_valid_d = bus.dec_valid;
      if (bus.dec_valid) begin
        out_v_d    = op_val;
        out_q_d    = op_tag;
        out_busy_d = op_busy;
        out_rd_d   = bus.dec_rd;
        out_tag_d  = bus.dec_tag;
      end
    end
  end

  // State register: reset clears everything, rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q     <= '{default: '0};
      tag_q       <= '{default: '0};
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_v_q     <= '{default: '0};
      out_q_q     <= '{default: '0};
      out_busy_q  <= '0;
      out_rd_q    <= '0;
      out_tag_q   <= '0;
    end else if (bus.rdy) begin
      value_q     <= value_d;
      tag_q       <= tag_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_v_q     <= out_v_d;
      out_q_q     <= out_q_d;
      out_busy_q  <= out_busy_d;
      out_rd_q    <= out_rd_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_v1    = out_v_q[0];
  assign bus.out_v2    = out_v_q[1];
  assign bus.out_q1    = out_q_q[0];
  assign bus.out_q2    = out_q_q[1];
  assign bus.out_busy1 = out_busy_q[0];
  assign bus.out_busy2 = out_busy_q[1];
  assign bus.out_rd    = out_rd_q;
  assign bus.out_tag   = out_tag_q;

endmodule
